// File: rtl/p0_input_conditioner.sv
// P0 pin conditioner: per-bit 2-FF synchroniser, optional debounce filter and
// registered rise/fall event flags feeding the 8051 core and interrupt logic.
module p0_input_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [WIDTH-1:0] bypass_mask,
    output logic [WIDTH-1:0] P0,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] rise_pulse,
    output logic             any_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            r_sync1;
    logic [WIDTH-1:0]            r_sync2;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0]            w_p0_next;
    logic [WIDTH-1:0]            w_fall_next;
    logic [WIDTH-1:0]            w_rise_next;

    // Synchronisers idle high so a released reset looks like the pull-up level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= pins_in;
            r_sync2 <= r_sync1;
        end
    end

    // A differing level must persist for the full count; any reversal clears it.
    always_comb begin
        w_cnt_next = '0;
        w_p0_next  = P0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass_mask[i]) begin
                w_p0_next[i] = r_sync2[i];
            end else if (r_sync2[i] != P0[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_p0_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_fall_next = P0 & ~w_p0_next;
    assign w_rise_next = ~P0 & w_p0_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            P0         <= '1;
            r_cnt      <= '0;
            fall_pulse <= '0;
            rise_pulse <= '0;
            any_fall   <= 1'b0;
        end else begin
            P0         <= w_p0_next;
            r_cnt      <= w_cnt_next;
            fall_pulse <= w_fall_next;
            rise_pulse <= w_rise_next;
            any_fall   <= |w_fall_next;
        end
    end

endmodule

// File: tb/tb_p0_input_conditioner.sv
// Directed bench for p0_input_conditioner: default debounce build plus a
// DEBOUNCE_CYCLES=1 build sharing clock and reset.
module tb_p0_input_conditioner;

    logic       clock;
    logic       reset;
    logic [7:0] pinsIn;
    logic [7:0] bypassMask;
    logic [7:0] p0;
    logic [7:0] fallPulse;
    logic [7:0] risePulse;
    logic       anyFall;

    logic [7:0] pinsIn1;
    logic [7:0] p0One;
    logic [7:0] fallOne;
    logic [7:0] riseOne;
    logic       anyFallOne;

    int testsRun  = 0;
    int failCount = 0;

    p0_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .pins_in     (pinsIn),
        .bypass_mask (bypassMask),
        .P0          (p0),
        .fall_pulse  (fallPulse),
        .rise_pulse  (risePulse),
        .any_fall    (anyFall)
    );

    p0_input_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dutOne (
        .clock       (clock),
        .reset       (reset),
        .pins_in     (pinsIn1),
        .bypass_mask (8'h00),
        .P0          (p0One),
        .fall_pulse  (fallOne),
        .rise_pulse  (riseOne),
        .any_fall    (anyFallOne)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        pinsIn = 8'hFF;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic bad;
        reset      = 1'b1;
        pinsIn     = 8'hFF;
        pinsIn1    = 8'hFF;
        bypassMask = 8'h00;
        repeat (2) tick();
        reset = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if ({p0, fallPulse, risePulse, anyFall} !== {8'hFF, 8'h00, 8'h00, 1'b0}) bad = 1'b1;
        end
        testsRun++;
        if (bad !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_idle: got P0=%h fall=%h rise=%h expected P0=ff no pulses", p0, fallPulse, risePulse);
        end
    endtask

    task automatic test_all_fall_and_async_reset();
        pinsIn = 8'h00;
        repeat (17) tick();
        testsRun++;
        if (p0 !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL all_fall_early: got %h expected ff", p0);
        end
        tick();
        testsRun++;
        if ({p0, fallPulse, anyFall} !== {8'h00, 8'hFF, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL all_fall_edge18: got P0=%h fall=%h any=%b expected P0=00 fall=ff any=1", p0, fallPulse, anyFall);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if ({p0, fallPulse, risePulse, anyFall} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL async_reset: got P0=%h fall=%h rise=%h any=%b expected ff/00/00/0", p0, fallPulse, risePulse, anyFall);
        end
        tick();
        reset = 1'b0;
        repeat (17) tick();
        testsRun++;
        if (p0 !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL post_reset_early: got %h expected ff", p0);
        end
        tick();
        testsRun++;
        if ({p0, fallPulse, anyFall} !== {8'h00, 8'hFF, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL post_reset_fall: got P0=%h fall=%h any=%b expected 00/ff/1", p0, fallPulse, anyFall);
        end
        pinsIn = 8'hFF;
        repeat (18) tick();
        testsRun++;
        if ({p0, risePulse, fallPulse, anyFall} !== {8'hFF, 8'hFF, 8'h00, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL all_rise: got P0=%h rise=%h fall=%h any=%b expected ff/ff/00/0", p0, risePulse, fallPulse, anyFall);
        end
        idle(3);
    endtask

    task automatic test_single_edge();
        logic bad;
        pinsIn = 8'hFE;
        bad    = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (p0 !== 8'hFF || fallPulse !== 8'h00) bad = 1'b1;
        end
        testsRun++;
        if (bad !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL fall0_early: got P0=%h fall=%h expected ff/00 before edge 18", p0, fallPulse);
        end
        tick();
        testsRun++;
        if ({p0, fallPulse, risePulse, anyFall} !== {8'hFE, 8'h01, 8'h00, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL fall0_edge18: got P0=%h fall=%h rise=%h any=%b expected fe/01/00/1", p0, fallPulse, risePulse, anyFall);
        end
        tick();
        testsRun++;
        if ({p0, fallPulse, anyFall} !== {8'hFE, 8'h00, 1'b0}) begin
            failCount++;
            $display("[TB] FAIL fall0_one_cycle: got P0=%h fall=%h any=%b expected fe/00/0", p0, fallPulse, anyFall);
        end
        pinsIn = 8'hFF;
        repeat (17) tick();
        testsRun++;
        if (p0 !== 8'hFE) begin
            failCount++;
            $display("[TB] FAIL rise0_early: got %h expected fe", p0);
        end
        tick();
        testsRun++;
        if ({p0, risePulse, fallPulse} !== {8'hFF, 8'h01, 8'h00}) begin
            failCount++;
            $display("[TB] FAIL rise0_edge18: got P0=%h rise=%h fall=%h expected ff/01/00", p0, risePulse, fallPulse);
        end
        tick();
        testsRun++;
        if (risePulse !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL rise0_one_cycle: got %h expected 00", risePulse);
        end
        idle(3);
    endtask

    task automatic test_glitch();
        logic bad;
        pinsIn = 8'hFE;
        repeat (10) tick();
        pinsIn = 8'hFF;
        bad    = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (p0 !== 8'hFF || fallPulse !== 8'h00 || risePulse !== 8'h00) bad = 1'b1;
        end
        testsRun++;
        if (bad !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL glitch10: got P0=%h fall=%h rise=%h expected ff/00/00", p0, fallPulse, risePulse);
        end
        pinsIn = 8'hFE;
        repeat (15) tick();
        pinsIn = 8'hFF;
        tick();
        pinsIn = 8'hFE;
        bad    = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (p0 !== 8'hFF || fallPulse !== 8'h00) bad = 1'b1;
        end
        testsRun++;
        if (bad !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL glitch_restart_early: got P0=%h fall=%h expected ff/00", p0, fallPulse);
        end
        tick();
        testsRun++;
        if ({p0, fallPulse} !== {8'hFE, 8'h01}) begin
            failCount++;
            $display("[TB] FAIL glitch_restart_fall: got P0=%h fall=%h expected fe/01", p0, fallPulse);
        end
        idle(20);
    endtask

    task automatic test_bypass();
        logic       val;
        logic [7:0] expFall;
        logic [7:0] expRise;
        bypassMask = 8'h02;
        val        = 1'b1;
        for (int ph = 0; ph < 6; ph++) begin
            val     = ~val;
            pinsIn  = {6'h3F, val, 1'b1};
            expFall = val ? 8'h00 : 8'h02;
            expRise = val ? 8'h02 : 8'h00;
            repeat (2) tick();
            testsRun++;
            if (p0[1] !== ~val) begin
                failCount++;
                $display("[TB] FAIL bypass_hold ph%0d: got %b expected %b", ph, p0[1], ~val);
            end
            tick();
            testsRun++;
            if ({p0[1], p0[0], fallPulse, risePulse} !== {val, 1'b1, expFall, expRise}) begin
                failCount++;
                $display("[TB] FAIL bypass_edge3 ph%0d: got P0=%h fall=%h rise=%h expected bit1=%b fall=%h rise=%h",
                         ph, p0, fallPulse, risePulse, val, expFall, expRise);
            end
            tick();
            testsRun++;
            if ({fallPulse, risePulse} !== 16'h0000) begin
                failCount++;
                $display("[TB] FAIL bypass_pulse_clear ph%0d: got fall=%h rise=%h expected 00/00", ph, fallPulse, risePulse);
            end
        end
        bypassMask = 8'h00;
        idle(3);
    endtask

    task automatic test_bypass_midcount();
        pinsIn = 8'hFB;
        repeat (12) tick();
        testsRun++;
        if (p0 !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL midcount_hold: got %h expected ff", p0);
        end
        bypassMask = 8'h04;
        tick();
        testsRun++;
        if ({p0, fallPulse, anyFall} !== {8'hFB, 8'h04, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL midcount_bypass: got P0=%h fall=%h any=%b expected fb/04/1", p0, fallPulse, anyFall);
        end
        pinsIn = 8'hFF;
        repeat (3) tick();
        testsRun++;
        if ({p0, risePulse} !== {8'hFF, 8'h04}) begin
            failCount++;
            $display("[TB] FAIL midcount_rise: got P0=%h rise=%h expected ff/04", p0, risePulse);
        end
        bypassMask = 8'h00;
        idle(3);
    endtask

    task automatic test_debounce_one();
        pinsIn1 = 8'hF7;
        repeat (2) tick();
        testsRun++;
        if (p0One !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL dc1_early: got %h expected ff", p0One);
        end
        tick();
        testsRun++;
        if ({p0One, fallOne, anyFallOne} !== {8'hF7, 8'h08, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL dc1_step: got P0=%h fall=%h any=%b expected f7/08/1", p0One, fallOne, anyFallOne);
        end
        pinsIn1 = 8'hFF;
        repeat (5) tick();
        pinsIn1 = 8'hF7;
        tick();
        pinsIn1 = 8'hFF;
        tick();
        tick();
        testsRun++;
        if ({p0One, fallOne, riseOne} !== {8'hF7, 8'h08, 8'h00}) begin
            failCount++;
            $display("[TB] FAIL dc1_glitch_fall: got P0=%h fall=%h rise=%h expected f7/08/00", p0One, fallOne, riseOne);
        end
        tick();
        testsRun++;
        if ({p0One, fallOne, riseOne} !== {8'hFF, 8'h00, 8'h08}) begin
            failCount++;
            $display("[TB] FAIL dc1_glitch_rise: got P0=%h fall=%h rise=%h expected ff/00/08", p0One, fallOne, riseOne);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_all_fall_and_async_reset();
        test_single_edge();
        test_glitch();
        test_bypass();
        test_bypass_midcount();
        test_debounce_one();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
